multiplier_arbiter: RTL and testbench

MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

---
 rtl/multiplier_arbiter.sv | 142 ++++++++++++++
 tb/tb_multiplier_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_arbiter.sv
// Round-robin arbiter sharing one unsigned multiplier among NUM_REQ requesters.
// One multiplication in flight at a time; the product is returned with its requester id.
module multiplier_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int INPUT_LENGTH  = 16,
    parameter int OUTPUT_LENGTH = 32,
    localparam int IdW          = $clog2(NUM_REQ)
) (
    input  logic                            iClk,
    input  logic                            iRst,
    input  logic [NUM_REQ-1:0]              iReq,
    input  logic [NUM_REQ*INPUT_LENGTH-1:0] iA,
    input  logic [NUM_REQ*INPUT_LENGTH-1:0] iB,
    output logic [NUM_REQ-1:0]              oAck,
    output logic [OUTPUT_LENGTH-1:0]        oRes,
    output logic                            oResValid,
    output logic [IdW-1:0]                  oResId,
    output logic                            oMulStart,
    output logic [INPUT_LENGTH-1:0]         oMulA,
    output logic [INPUT_LENGTH-1:0]         oMulB,
    input  logic                            iMulReady,
    input  logic                            iMulDone,
    input  logic [OUTPUT_LENGTH-1:0]        iMulRes
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE,
        RESPOND
    } stateT;

    stateT          state;
    stateT          stateNext;
    logic [IdW-1:0] rPtr;
    logic [IdW-1:0] rIdx;
    logic           rBusySeen;
    logic [IdW-1:0] winner;
    logic           found;
    logic [IdW:0]   scan;
    logic           grant;
    logic           capture;
    logic [IdW-1:0] ptrNext;

    // First requester at or above rPtr, wrapping back to 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        scan   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan = {1'b0, rPtr} + (IdW+1)'(i);
            if (scan >= (IdW+1)'(NUM_REQ)) begin
                scan = scan - (IdW+1)'(NUM_REQ);
            end
            if (!found && iReq[scan[IdW-1:0]]) begin
                found  = 1'b1;
                winner = scan[IdW-1:0];
            end
        end
    end

    assign ptrNext = (rIdx == IdW'(NUM_REQ-1)) ? '0 : rIdx + 1'b1;

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        grant     = 1'b0;
        capture   = 1'b0;
        unique case (state)
            IDLE: begin
                if (iMulReady && found) begin
                    grant     = 1'b1;
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                stateNext = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A done seen before the multiplier went busy belongs to an older job.
                if (iMulDone && rBusySeen) begin
                    capture   = 1'b1;
                    stateNext = RESPOND;
                end
            end
            RESPOND: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            rPtr      <= '0;
            rIdx      <= '0;
            rBusySeen <= 1'b0;
            oAck      <= '0;
            oResValid <= 1'b0;
            oMulStart <= 1'b0;
            oMulA     <= '0;
            oMulB     <= '0;
            oRes      <= '0;
            oResId    <= '0;
        end else begin
            oAck      <= '0;
            oMulStart <= 1'b0;
            oResValid <= 1'b0;
            if (grant) begin
                oAck      <= NUM_REQ'(1) << winner;
                oMulStart <= 1'b1;
                oMulA     <= iA[int'(winner)*INPUT_LENGTH +: INPUT_LENGTH];
                oMulB     <= iB[int'(winner)*INPUT_LENGTH +: INPUT_LENGTH];
                rIdx      <= winner;
            end
            if (state == ISSUE) begin
                rBusySeen <= 1'b0;
            end
            if (state == WAIT_DONE && !iMulReady) begin
                rBusySeen <= 1'b1;
            end
            if (capture) begin
                oRes <= iMulRes;
            end
            if (state == RESPOND) begin
                oResValid <= 1'b1;
                oResId    <= rIdx;
                rPtr      <= ptrNext;
            end
        end
    end

endmodule

// File: tb/tb_multiplier_arbiter.sv
// Bench for multiplier_arbiter: behavioural multiplier, event monitor,
// directed scenarios and randomized rounds against a round-robin model.
module tb_multiplier_arbiter;

    localparam int N  = 4;
    localparam int IW = 16;
    localparam int OW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  req;
    logic [N*IW-1:0] a;
    logic [N*IW-1:0] b;
    logic [N-1:0]  ack;
    logic [OW-1:0] res;
    logic          resValid;
    logic [1:0]    resId;
    logic          mulStart;
    logic [IW-1:0] mulA;
    logic [IW-1:0] mulB;
    logic          mulReady;
    logic          mulDone;
    logic [OW-1:0] mulRes;

    always #5 clk = ~clk;

    multiplier_arbiter #(
        .NUM_REQ(N),
        .INPUT_LENGTH(IW),
        .OUTPUT_LENGTH(OW)
    ) dut (
        .iClk(clk),
        .iRst(rst),
        .iReq(req),
        .iA(a),
        .iB(b),
        .oAck(ack),
        .oRes(res),
        .oResValid(resValid),
        .oResId(resId),
        .oMulStart(mulStart),
        .oMulA(mulA),
        .oMulB(mulB),
        .iMulReady(mulReady),
        .iMulDone(mulDone),
        .iMulRes(mulRes)
    );

    // Multiplier: busy for mulLat cycles after start, then done with ready.
    int   mulLat;
    logic forceDone;
    logic mBusy;
    logic mDone;
    int   mCnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mBusy  <= 1'b0;
            mDone  <= 1'b0;
            mCnt   <= 0;
            mulRes <= '0;
        end else begin
            mDone <= 1'b0;
            if (!mBusy && mulStart) begin
                mBusy <= 1'b1;
                mCnt  <= mulLat - 1;
            end else if (mBusy) begin
                if (mCnt == 0) begin
                    mBusy  <= 1'b0;
                    mDone  <= 1'b1;
                    mulRes <= OW'(mulA) * OW'(mulB);
                end else begin
                    mCnt <= mCnt - 1;
                end
            end
        end
    end

    assign mulReady = !mBusy;
    assign mulDone  = mDone | forceDone;

    typedef struct {
        int            id;
        logic [OW-1:0] val;
        int            cyc;
    } resT;

    resT          resQ[$];
    logic [N-1:0] ackVal[$];
    int           ackCyc[$];
    int           startCnt;
    int           cyc;

    always @(posedge clk) begin
        #1;
        cyc++;
        if (resValid) resQ.push_back('{int'(resId), res, cyc});
        if (ack != '0) begin
            ackVal.push_back(ack);
            ackCyc.push_back(cyc);
        end
        if (mulStart) startCnt++;
    end

    int           nChecks;
    int           nErrors;
    int           rBase;
    int           aBase;
    int           sBase;
    int           modelPtr;
    logic [N-1:0] holdMask;
    logic [IW-1:0] opA[N];
    logic [IW-1:0] opB[N];

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic stepCycle();
        @(negedge clk);
        req = req & ~(ack & ~holdMask);
    endtask

    task automatic setOp(int k, logic [IW-1:0] av, logic [IW-1:0] bv);
        opA[k] = av;
        opB[k] = bv;
        a[k*IW +: IW] = av;
        b[k*IW +: IW] = bv;
    endtask

    task automatic waitRes(string tag, int n, int budget);
        int k;
        k = 0;
        while (resQ.size() - rBase < n && k < budget) begin
            stepCycle();
            k++;
        end
        chk(tag, resQ.size() - rBase, n);
    endtask

    task automatic waitAck(string tag, int n, int budget);
        int k;
        k = 0;
        while (ackVal.size() - aBase < n && k < budget) begin
            stepCycle();
            k++;
        end
        chk(tag, ackVal.size() - aBase, n);
    endtask

    task automatic markBase();
        rBase = resQ.size();
        aBase = ackVal.size();
        sBase = startCnt;
    endtask

    task automatic doReset();
        @(negedge clk);
        req = '0;
        forceDone = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelPtr = 0;
    endtask

    task automatic chkAllZero(string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_valid"}, resValid, 0);
        chk({tag, "_start"}, mulStart, 0);
        chk({tag, "_mulA"}, mulA, 0);
        chk({tag, "_mulB"}, mulB, 0);
        chk({tag, "_res"}, res, 0);
        chk({tag, "_id"}, resId, 0);
    endtask

    // Round-robin reference: first requested index counting up from ptr.
    function automatic int nextWinner(logic [N-1:0] mask, int ptr);
        for (int i = 0; i < N; i++) begin
            if (mask[(ptr + i) % N]) return (ptr + i) % N;
        end
        return -1;
    endfunction

    function automatic longint prod(int k);
        return longint'(opA[k]) * longint'(opB[k]);
    endfunction

    initial begin
        logic [N-1:0] m;
        int w;
        int cnt;

        rst = 1'b0;
        req = '0;
        a = '0;
        b = '0;
        holdMask = '0;
        forceDone = 1'b0;
        mulLat = 3;
        modelPtr = 0;
        #2 rst = 1'b1;
        #1 chkAllZero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single request
        markBase();
        mulLat = $urandom_range(1, 5);
        setOp(0, 16'd3, 16'd5);
        req = 4'b0001;
        waitRes("single_cnt", 1, 60);
        repeat (4) stepCycle();
        chk("single_ack_cnt", ackVal.size() - aBase, 1);
        chk("single_ack", ackVal[aBase], 4'b0001);
        chk("single_starts", startCnt - sBase, 1);
        chk("single_res", resQ[rBase].val, 15);
        chk("single_id", resQ[rBase].id, 0);
        chk("single_lat", resQ[rBase].cyc - ackCyc[aBase], mulLat + 3);
        chk("single_pulse", resQ.size() - rBase, 1);
        chk("single_hold", res, 15);
        modelPtr = 1;

        // Contention from a fresh reset
        doReset();
        markBase();
        mulLat = $urandom_range(1, 5);
        for (int k = 0; k < N; k++) setOp(k, IW'(k + 1), 16'd10);
        holdMask = 4'hF;
        req = 4'hF;
        waitAck("cont_acks", 5, 200);
        req = '0;
        holdMask = '0;
        waitRes("cont_cnt", 5, 200);
        for (int i = 0; i < 5; i++) begin
            w = nextWinner(4'hF, modelPtr);
            chk("cont_id", resQ[rBase + i].id, w);
            chk("cont_res", resQ[rBase + i].val, prod(w));
            modelPtr = (w + 1) % N;
        end
        chk("cont_id0_first", resQ[rBase].id, 0);
        chk("cont_res4", resQ[rBase + 3].val, 40);
        chk("cont_starts", startCnt - sBase, 5);

        // Maximum operands
        markBase();
        setOp(2, 16'hFFFF, 16'hFFFF);
        req = 4'b0100;
        waitRes("max_cnt", 1, 60);
        chk("max_res", resQ[rBase].val, 32'hFFFE0001);
        chk("max_id", resQ[rBase].id, 2);
        modelPtr = 3;

        // Late request arrives while busy
        markBase();
        mulLat = 5;
        setOp(0, IW'($urandom), IW'($urandom));
        req = 4'b0001;
        waitAck("late_ack0", 1, 20);
        repeat (2) stepCycle();
        setOp(3, IW'($urandom), IW'($urandom));
        req[3] = 1'b1;
        waitRes("late_cnt", 2, 100);
        chk("late_id0", resQ[rBase].id, 0);
        chk("late_res0", resQ[rBase].val, prod(0));
        chk("late_id3", resQ[rBase + 1].id, 3);
        chk("late_res3", resQ[rBase + 1].val, prod(3));
        chk("late_ack3_cyc", ackCyc[aBase + 1], resQ[rBase].cyc + 1);
        chk("late_starts", startCnt - sBase, 2);
        modelPtr = 0;

        // Reset during WAIT_DONE
        markBase();
        mulLat = 6;
        setOp(2, IW'($urandom_range(1, 16'hFFFF)), IW'($urandom_range(1, 16'hFFFF)));
        req = 4'b0100;
        waitAck("rst_ack", 1, 20);
        repeat (2) stepCycle();
        #1 rst = 1'b1;
        #1 chkAllZero("midrst");
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        modelPtr = 0;
        markBase();
        repeat (15) stepCycle();
        chk("midrst_no_valid", resQ.size() - rBase, 0);
        setOp(2, IW'($urandom), IW'($urandom));
        req = 4'b0100;
        waitRes("midrst_cnt", 1, 60);
        chk("midrst_id", resQ[rBase].id, 2);
        chk("midrst_res", resQ[rBase].val, prod(2));
        modelPtr = 3;

        // Stale done held through ISSUE and the first busy cycle
        markBase();
        mulLat = 4;
        setOp(1, IW'($urandom), IW'($urandom));
        req = 4'b0010;
        forceDone = 1'b1;
        repeat (3) stepCycle();
        forceDone = 1'b0;
        chk("stale_early", resQ.size() - rBase, 0);
        waitRes("stale_cnt", 1, 60);
        chk("stale_res", resQ[rBase].val, prod(1));
        chk("stale_id", resQ[rBase].id, 1);
        chk("stale_lat", resQ[rBase].cyc - ackCyc[aBase], mulLat + 3);
        modelPtr = 2;

        // Randomized rounds
        for (int r = 0; r < 20; r++) begin
            markBase();
            m = N'($urandom_range(1, 15));
            mulLat = $urandom_range(1, 6);
            for (int k = 0; k < N; k++) setOp(k, IW'($urandom), IW'($urandom));
            cnt = $countones(m);
            req = m;
            waitRes("rnd_cnt", cnt, 300);
            for (int i = 0; i < cnt; i++) begin
                w = nextWinner(m, modelPtr);
                chk("rnd_id", resQ[rBase + i].id, w);
                chk("rnd_res", resQ[rBase + i].val, prod(w));
                m[w] = 1'b0;
                modelPtr = (w + 1) % N;
            end
            chk("rnd_starts", startCnt - sBase, cnt);
            repeat (2) stepCycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
